// File: rtl/vector_merge_sequencer.sv
// Purpose: vmerge/vmv over a VLEN-wide register, producing one ELEN-bit beat of vd per cycle.
// Latency: out_valid rises BEATS+1 cycles after the accept edge (1 cycle when vl=0); one op in flight.
// Backpressure: the result is held in DONE until out_ready; in_ready stays low from accept until after the handoff.
// Ports:
//   clock, reset_n         - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    - request handshake; all operands are captured on the accept edge
//   sew, vl, vm, op_sel    - element width, active length, mask enable, source select (vv/vx/vi)
//   vs2, vs1, scalar, simm5- false-select operand and the three true-select sources
//   v0, vd_old             - mask register and prior destination (tail source)
//   out_valid / out_ready  - result handshake; vd is the completed destination register
// VLEN and ELEN are expected to be powers of two with VLEN > ELEN.
module vector_merge_sequencer #(
  parameter int VLEN          = 256,
  parameter int ELEN          = 64,
  parameter bit TAIL_AGNOSTIC = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              sew,
  input  logic [$clog2(VLEN/8):0] vl,
  input  logic                    vm,
  input  logic [1:0]              op_sel,
  input  logic [VLEN-1:0]         vs2,
  input  logic [VLEN-1:0]         vs1,
  input  logic [ELEN-1:0]         scalar,
  input  logic [4:0]              simm5,
  input  logic [VLEN-1:0]         v0,
  input  logic [VLEN-1:0]         vd_old,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VLEN-1:0]         vd
);

  localparam int BEATS = VLEN / ELEN;
  localparam int VB    = VLEN / 8;       // bytes per register
  localparam int BPB   = ELEN / 8;       // bytes per beat
  localparam int VLW   = $clog2(VB) + 1; // vl width
  localparam int GBW   = $clog2(VB);     // byte index / element index width
  localparam int BPW   = $clog2(BPB);    // byte-within-beat index width
  localparam int BIW   = $clog2(BEATS);  // beat index width
  localparam int BW    = BIW + 1;        // beat counter also reaches BEATS
  localparam int AW    = $clog2(VLEN);   // bit index into a register
  localparam int EW    = $clog2(ELEN);   // bit index into a beat

  localparam logic [VLW-1:0] VB_L    = VLW'(VB);
  localparam logic [BW-1:0]  BEATS_L = BW'(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [1:0]        sew_q, sew_d;
  logic [VLW-1:0]    vl_q, vl_d;
  logic              vm_q, vm_d;
  logic [1:0]        op_sel_q, op_sel_d;
  logic [VLEN-1:0]   vs2_q, vs2_d;
  logic [VLEN-1:0]   vs1_q, vs1_d;
  logic [ELEN-1:0]   scalar_q, scalar_d;
  logic [4:0]        simm5_q, simm5_d;
  logic [VLEN-1:0]   v0_q, v0_d;
  logic [VLEN-1:0]   vd_old_q, vd_old_d;
  logic [VLEN-1:0]   vd_q, vd_d;

  logic [VLW-1:0]    vlmax_in;
  logic [BIW-1:0]    beat_idx;
  logic [GBW-1:0]    beat_base;
  logic [BPW-1:0]    elem_mask;
  logic [ELEN-1:0]   beat_res;
  logic [GBW-1:0]    gb;
  logic [GBW-1:0]    e_idx;
  logic [BPW-1:0]    jb;
  logic [7:0]        src_b;

  // VLMAX = VLEN/SEW elements = register bytes >> sew.
  assign vlmax_in  = VB_L >> sew;
  assign beat_idx  = beat_q[BIW-1:0];
  assign beat_base = {beat_idx, {BPW{1'b0}}};
  // Low 'sew' bits set: selects the byte position inside one element.
  assign elem_mask = ~({BPW{1'b1}} << sew_q);

  // ---------------- state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      sew_q    <= '0;
      vl_q     <= '0;
      vm_q     <= 1'b0;
      op_sel_q <= '0;
      vs2_q    <= '0;
      vs1_q    <= '0;
      scalar_q <= '0;
      simm5_q  <= '0;
      v0_q     <= '0;
      vd_old_q <= '0;
      vd_q     <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      sew_q    <= sew_d;
      vl_q     <= vl_d;
      vm_q     <= vm_d;
      op_sel_q <= op_sel_d;
      vs2_q    <= vs2_d;
      vs1_q    <= vs1_d;
      scalar_q <= scalar_d;
      simm5_q  <= simm5_d;
      v0_q     <= v0_d;
      vd_old_q <= vd_old_d;
      vd_q     <= vd_d;
    end
  end

  // ---------------- next-state logic ----------------
  // BUSY spends one cycle per beat plus a final cycle with beat == BEATS
  // before DONE; a zero vl skips the beats entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if ((vl_q == '0) || (beat_q == BEATS_L)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    vd        = vd_q;
  end

  // ---------------- one beat of merge results ----------------
  // Works byte by byte: the global byte index shifted right by sew is the
  // element number, so every SEW is handled by the same loop.
  always_comb begin
    beat_res = '0;
    gb       = '0;
    e_idx    = '0;
    jb       = '0;
    src_b    = '0;
    for (int b = 0; b < BPB; b++) begin
      gb    = beat_base | GBW'(b);
      e_idx = gb >> sew_q;
      jb    = BPW'(b) & elem_mask;
      case (op_sel_q)
        2'b01:   src_b = scalar_q[{jb, 3'b000} +: 8];
        // simm5 sign-extended: low byte carries the value, upper bytes the sign.
        2'b10:   src_b = (jb == '0) ? {{3{simm5_q[4]}}, simm5_q} : {8{simm5_q[4]}};
        default: src_b = vs1_q[{gb, 3'b000} +: 8];
      endcase
      if ({1'b0, e_idx} < vl_q) begin
        beat_res[b*8 +: 8] = (vm_q || v0_q[{{(AW-GBW){1'b0}}, e_idx}]) ?
                             src_b : vs2_q[{gb, 3'b000} +: 8];
      end else begin
        beat_res[b*8 +: 8] = TAIL_AGNOSTIC ? 8'hFF : vd_old_q[{gb, 3'b000} +: 8];
      end
    end
  end

  // ---------------- capture and datapath ----------------
  always_comb begin
    beat_d   = beat_q;
    sew_d    = sew_q;
    vl_d     = vl_q;
    vm_d     = vm_q;
    op_sel_d = op_sel_q;
    vs2_d    = vs2_q;
    vs1_d    = vs1_q;
    scalar_d = scalar_q;
    simm5_d  = simm5_q;
    v0_d     = v0_q;
    vd_old_d = vd_old_q;
    vd_d     = vd_q;
    if ((state_q == IDLE) && in_valid) begin
      beat_d   = '0;
      sew_d    = sew;
      vl_d     = (vl > vlmax_in) ? vlmax_in : vl;
      vm_d     = vm;
      op_sel_d = op_sel;
      vs2_d    = vs2;
      vs1_d    = vs1;
      scalar_d = scalar;
      simm5_d  = simm5;
      v0_d     = v0;
      vd_old_d = vd_old;
    end else if (state_q == BUSY) begin
      if (vl_q == '0) begin
        // Zero length leaves the destination untouched, even when tail-agnostic.
        vd_d = vd_old_q;
      end else if (beat_q != BEATS_L) begin
        vd_d[{beat_idx, {EW{1'b0}}} +: ELEN] = beat_res;
        beat_d = beat_q + 1'b1;
      end
    end
  end

endmodule
